// File: rtl/wb_commit_stage.sv
// wb_commit_stage: DEPTH-entry in-order commit buffer that retires one instruction per cycle
// Retire writes the GPR file, drives the CSR request port, and resolves exceptions/ERTN/interrupts.
// Optional build macro WB_PERF_CNT_EN adds retired_cnt/ex_cnt performance counter outputs.
module wb_commit_stage #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int DEPTH   = 2,
  parameter int ECODE_W = 6,
  parameter int ESUB_W  = 9
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ms_to_ws_valid,
  output logic                     ws_allowin,
  input  logic [31:0]              ms_pc,
  input  logic [DATA_W-1:0]        ms_result,
  input  logic [31:0]              ms_vaddr,
  input  logic                     ms_gr_we,
  input  logic [REG_AW-1:0]        ms_dest,
  input  logic                     ms_ex,
  input  logic [ECODE_W-1:0]       ms_ecode,
  input  logic [ESUB_W-1:0]        ms_esubcode,
  input  logic                     ms_ertn,
  input  logic                     ms_csr_re,
  input  logic                     ms_csr_we,
  input  logic [13:0]              ms_csr_num,
  input  logic [DATA_W-1:0]        ms_csr_wmask,
  input  logic [DATA_W-1:0]        ms_csr_wvalue,
  input  logic                     commit_hold,
  input  logic                     has_int,
  output logic [13:0]              csr_num,
  input  logic [DATA_W-1:0]        csr_rvalue,
  output logic                     csr_we,
  output logic [DATA_W-1:0]        csr_wmask,
  output logic [DATA_W-1:0]        csr_wvalue,
  output logic                     wb_ex,
  output logic [ECODE_W-1:0]       wb_ecode,
  output logic [ESUB_W-1:0]        wb_esubcode,
  output logic [31:0]              wb_pc,
  output logic [31:0]              wb_vaddr,
  output logic                     ertn_flush,
  output logic                     flush,
  output logic                     rf_we,
  output logic [REG_AW-1:0]        rf_waddr,
  output logic [DATA_W-1:0]        rf_wdata,
  output logic [$clog2(DEPTH):0]   buf_count
`ifdef WB_PERF_CNT_EN
  ,
  output logic [63:0]              retired_cnt,
  output logic [31:0]              ex_cnt
`endif
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [31:0]         pc;
    logic [DATA_W-1:0]   result;
    logic [31:0]         vaddr;
    logic                gr_we;
    logic [REG_AW-1:0]   dest;
    logic                ex;
    logic [ECODE_W-1:0]  ecode;
    logic [ESUB_W-1:0]   esub;
    logic                ertn;
    logic                csr_re;
    logic                csr_we;
    logic [13:0]         csr_num;
    logic [DATA_W-1:0]   csr_wmask;
    logic [DATA_W-1:0]   csr_wvalue;
  } entry_t;

  entry_t          r_buf [DEPTH];
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [CW-1:0]   r_count;
  entry_t          w_in;
  entry_t          w_head;
  logic            w_fire;
  logic            w_enq;
  logic            w_int;
  logic            w_exc;
  logic            w_ertn;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // pack the upstream fields into one buffer entry
  always_comb begin
    w_in = '{pc: ms_pc, result: ms_result, vaddr: ms_vaddr, gr_we: ms_gr_we,
             dest: ms_dest, ex: ms_ex, ecode: ms_ecode, esub: ms_esubcode,
             ertn: ms_ertn, csr_re: ms_csr_re, csr_we: ms_csr_we,
             csr_num: ms_csr_num, csr_wmask: ms_csr_wmask,
             csr_wvalue: ms_csr_wvalue};
  end

  // head classification; reset gates fire so nothing retires in a reset cycle
  always_comb begin
    w_head     = r_buf[r_head];
    w_fire     = (r_count != '0) & ~commit_hold & ~reset;
    w_int      = has_int & ~w_head.ex;
    w_exc      = w_head.ex | w_int;
    w_ertn     = w_head.ertn & ~w_exc;
    ws_allowin = (r_count < CW'(DEPTH)) | w_fire;
    w_enq      = ms_to_ws_valid & ws_allowin & ~flush;
  end

  // retire-side strobes and head-sourced data outputs
  always_comb begin
    wb_ex       = w_fire & w_exc;
    ertn_flush  = w_fire & w_ertn;
    flush       = wb_ex | ertn_flush;
    csr_we      = w_fire & w_head.csr_we & ~w_exc;
    rf_we       = w_fire & w_head.gr_we & ~w_exc;
    csr_num     = w_head.csr_num;
    csr_wmask   = w_head.csr_wmask;
    csr_wvalue  = w_head.csr_wvalue;
    wb_ecode    = w_int ? '0 : w_head.ecode;
    wb_esubcode = w_int ? '0 : w_head.esub;
    wb_pc       = w_head.pc;
    wb_vaddr    = w_head.vaddr;
    rf_waddr    = w_head.dest;
    rf_wdata    = w_head.csr_re ? csr_rvalue : w_head.result;
    buf_count   = r_count;
  end

  // entry payload storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (w_enq) r_buf[r_tail] <= w_in;
  end

  // pointers and occupancy; a flush empties the buffer and rewinds both pointers
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_tail <= ptr_inc(r_tail);
      if (w_fire) r_head <= ptr_inc(r_head);
      r_count <= r_count + CW'(w_enq) - CW'(w_fire);
    end
  end

`ifdef WB_PERF_CNT_EN
  logic [63:0] r_retired_cnt;
  logic [31:0] r_ex_cnt;

  // count clean retires (ERTN included) and exception retires
  always_ff @(posedge clk) begin
    if (reset) begin
      r_retired_cnt <= '0;
      r_ex_cnt      <= '0;
    end else begin
      if (w_fire && !w_exc) r_retired_cnt <= r_retired_cnt + 64'd1;
      if (wb_ex) r_ex_cnt <= r_ex_cnt + 32'd1;
    end
  end

  assign retired_cnt = r_retired_cnt;
  assign ex_cnt      = r_ex_cnt;
`endif
endmodule

// File: tb/tb_wb_commit_stage.sv
// tb_wb_commit_stage: directed checks of the commit buffer, flush, interrupt, ERTN and CSR paths
module tb_wb_commit_stage;
  logic        clk = 0;
  logic        reset;
  logic        ms_to_ws_valid;
  logic        ws_allowin;
  logic [31:0] ms_pc, ms_result, ms_vaddr;
  logic        ms_gr_we;
  logic [4:0]  ms_dest;
  logic        ms_ex;
  logic [5:0]  ms_ecode;
  logic [8:0]  ms_esubcode;
  logic        ms_ertn, ms_csr_re, ms_csr_we;
  logic [13:0] ms_csr_num;
  logic [31:0] ms_csr_wmask, ms_csr_wvalue;
  logic        commit_hold, has_int;
  logic [13:0] csr_num;
  logic [31:0] csr_rvalue;
  logic        csr_we;
  logic [31:0] csr_wmask, csr_wvalue;
  logic        wb_ex;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc, wb_vaddr;
  logic        ertn_flush, flush, rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [1:0]  buf_count;
`ifdef WB_PERF_CNT_EN
  logic [63:0] retired_cnt;
  logic [31:0] ex_cnt;
`endif
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wb_commit_stage dut (
    .clk(clk), .reset(reset), .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
    .ms_pc(ms_pc), .ms_result(ms_result), .ms_vaddr(ms_vaddr), .ms_gr_we(ms_gr_we),
    .ms_dest(ms_dest), .ms_ex(ms_ex), .ms_ecode(ms_ecode), .ms_esubcode(ms_esubcode),
    .ms_ertn(ms_ertn), .ms_csr_re(ms_csr_re), .ms_csr_we(ms_csr_we),
    .ms_csr_num(ms_csr_num), .ms_csr_wmask(ms_csr_wmask), .ms_csr_wvalue(ms_csr_wvalue),
    .commit_hold(commit_hold), .has_int(has_int), .csr_num(csr_num),
    .csr_rvalue(csr_rvalue), .csr_we(csr_we), .csr_wmask(csr_wmask),
    .csr_wvalue(csr_wvalue), .wb_ex(wb_ex), .wb_ecode(wb_ecode),
    .wb_esubcode(wb_esubcode), .wb_pc(wb_pc), .wb_vaddr(wb_vaddr),
    .ertn_flush(ertn_flush), .flush(flush), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .buf_count(buf_count)
`ifdef WB_PERF_CNT_EN
    , .retired_cnt(retired_cnt), .ex_cnt(ex_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] res, input logic [4:0] dest);
    ms_to_ws_valid = 1; ms_pc = pc; ms_result = res; ms_vaddr = 0; ms_gr_we = 1;
    ms_dest = dest; ms_ex = 0; ms_ecode = 0; ms_esubcode = 0; ms_ertn = 0;
    ms_csr_re = 0; ms_csr_we = 0; ms_csr_num = 0; ms_csr_wmask = 0; ms_csr_wvalue = 0;
  endtask

  task automatic idle();
    ms_to_ws_valid = 0;
  endtask

  task automatic strobes_off(input string tag);
    chk({tag, ".rf_we"}, rf_we, 0);
    chk({tag, ".csr_we"}, csr_we, 0);
    chk({tag, ".wb_ex"}, wb_ex, 0);
    chk({tag, ".ertn"}, ertn_flush, 0);
    chk({tag, ".flush"}, flush, 0);
  endtask

  initial begin
    reset = 1; commit_hold = 0; has_int = 0; csr_rvalue = 0;
    push(0, 0, 0); idle();
    @(negedge clk); #1;
    strobes_off("rst");
    chk("rst.count", buf_count, 0);
    reset = 0;
    @(negedge clk); #1;
    chk("rst.allowin", ws_allowin, 1);
    // back-to-back A, B
    @(negedge clk); push(32'h1c000000, 5, 4); #1;
    chk("ab.allowin", ws_allowin, 1);
    chk("ab.c1_rf_we", rf_we, 0);
    @(negedge clk); push(32'h1c000004, 7, 5); #1;
    chk("ab.a_we", rf_we, 1);
    chk("ab.a_addr", rf_waddr, 4);
    chk("ab.a_data", rf_wdata, 5);
    chk("ab.a_pc", wb_pc, 32'h1c000000);
    chk("ab.a_cnt", buf_count, 1);
    @(negedge clk); idle(); #1;
    chk("ab.b_we", rf_we, 1);
    chk("ab.b_addr", rf_waddr, 5);
    chk("ab.b_data", rf_wdata, 7);
    chk("ab.b_cnt", buf_count, 1);
    @(negedge clk); #1;
    chk("ab.empty", buf_count, 0);
    chk("ab.empty_we", rf_we, 0);
    // fill to full under hold, release with upstream valid
    commit_hold = 1; push(32'h1c000010, 32'h11, 7);
    @(negedge clk); push(32'h1c000014, 32'h22, 8); #1;
    chk("full.c1", buf_count, 1);
    chk("full.hold_we", rf_we, 0);
    chk("full.allow1", ws_allowin, 1);
    @(negedge clk); idle(); #1;
    chk("full.cnt", buf_count, 2);
    chk("full.allow0", ws_allowin, 0);
    @(negedge clk); commit_hold = 0; push(32'h1c000018, 32'h33, 9); #1;
    chk("full.rel_allow", ws_allowin, 1);
    chk("full.c_addr", rf_waddr, 7);
    chk("full.c_data", rf_wdata, 32'h11);
    @(negedge clk); idle(); #1;
    chk("full.stay2", buf_count, 2);
    chk("full.d_data", rf_wdata, 32'h22);
    @(negedge clk); #1;
    chk("full.e_data", rf_wdata, 32'h33);
    chk("full.e_cnt", buf_count, 1);
    @(negedge clk); #1;
    chk("full.drain", buf_count, 0);
    // exception at head with a second entry queued
    commit_hold = 1; push(32'h1c000100, 32'h99, 10);
    ms_ex = 1; ms_ecode = 6'h08; ms_esubcode = 9'h3; ms_csr_we = 1; ms_vaddr = 32'hdead0000;
    @(negedge clk); push(32'h1c000104, 32'h1, 11);
    @(negedge clk); commit_hold = 0; push(32'h1c000108, 32'h2, 12); #1;
    chk("exc.cnt", buf_count, 2);
    chk("exc.wb_ex", wb_ex, 1);
    chk("exc.ecode", wb_ecode, 6'h08);
    chk("exc.esub", wb_esubcode, 9'h3);
    chk("exc.flush", flush, 1);
    chk("exc.rf_we", rf_we, 0);
    chk("exc.csr_we", csr_we, 0);
    chk("exc.pc", wb_pc, 32'h1c000100);
    chk("exc.vaddr", wb_vaddr, 32'hdead0000);
    @(negedge clk); idle(); #1;
    chk("exc.after_cnt", buf_count, 0);
    strobes_off("exc.after");
    @(negedge clk); #1;
    chk("exc.dropped", buf_count, 0);
    // interrupt on a plain add
    push(32'h1c000200, 32'h44, 13); ms_ecode = 6'h3f; ms_esubcode = 9'h1ff;
    @(negedge clk); idle(); has_int = 1; #1;
    chk("int.wb_ex", wb_ex, 1);
    chk("int.ecode", wb_ecode, 0);
    chk("int.esub", wb_esubcode, 0);
    chk("int.rf_we", rf_we, 0);
    chk("int.pc", wb_pc, 32'h1c000200);
    chk("int.flush", flush, 1);
    @(negedge clk); has_int = 0; #1;
    chk("int.after", buf_count, 0);
    // ERTN clean, then ERTN carrying an exception
    push(32'h1c000300, 0, 0); ms_gr_we = 0; ms_ertn = 1;
    @(negedge clk); idle(); #1;
    chk("ertn.flush", ertn_flush, 1);
    chk("ertn.wb_ex", wb_ex, 0);
    chk("ertn.fl", flush, 1);
    @(negedge clk); push(32'h1c000304, 0, 0); ms_gr_we = 0; ms_ertn = 1; ms_ex = 1; ms_ecode = 6'h0c;
    @(negedge clk); idle(); #1;
    chk("ertnx.wb_ex", wb_ex, 1);
    chk("ertnx.ertn", ertn_flush, 0);
    chk("ertnx.ecode", wb_ecode, 6'h0c);
    // CSR read/write on retire
    @(negedge clk); push(32'h1c000400, 32'h1234, 6);
    ms_csr_re = 1; ms_csr_we = 1; ms_csr_num = 14'h5; ms_csr_wmask = 32'hff00ff00; ms_csr_wvalue = 32'h12345678;
    csr_rvalue = 32'habcd;
    @(negedge clk); idle(); #1;
    chk("csr.num", csr_num, 14'h5);
    chk("csr.rf_we", rf_we, 1);
    chk("csr.waddr", rf_waddr, 6);
    chk("csr.wdata", rf_wdata, 32'habcd);
    chk("csr.we", csr_we, 1);
    chk("csr.wmask", csr_wmask, 32'hff00ff00);
    chk("csr.wvalue", csr_wvalue, 32'h12345678);
    @(negedge clk); #1;
`ifdef WB_PERF_CNT_EN
    chk("perf.retired", retired_cnt, 7);
    chk("perf.ex", ex_cnt, 3);
`endif
    // reset while an entry is pending
    commit_hold = 1; push(32'h1c000500, 32'h77, 14);
    @(negedge clk); idle(); commit_hold = 0; reset = 1; #1;
    chk("mrst.cnt_before", buf_count, 1);
    strobes_off("mrst");
    @(negedge clk); reset = 0; #1;
    chk("mrst.cnt", buf_count, 0);
    chk("mrst.rf_we", rf_we, 0);
`ifdef WB_PERF_CNT_EN
    chk("mrst.perf", retired_cnt, 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/wb_commit_stage.md
Name: wb_commit_stage

Overview:
Parametrised successor to the single-entry write-back stage. Accepts instructions from the memory stage into a DEPTH-entry in-order commit buffer and retires at most one per cycle. At retire it writes the register file, performs CSR read/write, and resolves exceptions, ERTN and interrupts. CSR storage stays in the external CSR file. This block only drives its request interface and emits flush/redirect controls to the front end.

Parameters:
DATA_W, 32, register/result/CSR data width
REG_AW, 5, register-file address width
DEPTH, 2, commit buffer entries (power of 2, >=1)
ECODE_W, 6, exception code width
ESUB_W, 9, exception subcode width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
ms_to_ws_valid  in  1  upstream entry valid
ws_allowin  out  1  stage can accept this cycle
ms_pc  in  32  instruction PC
ms_result  in  DATA_W  ALU/load result
ms_vaddr  in  32  faulting virtual address
ms_gr_we  in  1  GPR write request
ms_dest  in  REG_AW  GPR destination
ms_ex  in  1  upstream exception flag
ms_ecode  in  ECODE_W  exception code
ms_esubcode  in  ESUB_W  exception subcode
ms_ertn  in  1  ERTN instruction
ms_csr_re  in  1  CSR read
ms_csr_we  in  1  CSR write
ms_csr_num  in  14  CSR number
ms_csr_wmask  in  DATA_W  CSR write mask
ms_csr_wvalue  in  DATA_W  CSR write value
commit_hold  in  1  external retire stall
has_int  in  1  pending enabled interrupt from CSR file
csr_num  out  14  CSR address, combinational from head
csr_rvalue  in  DATA_W  CSR read data, same cycle
csr_we  out  1  CSR write strobe
csr_wmask  out  DATA_W  CSR write mask
csr_wvalue  out  DATA_W  CSR write value
wb_ex  out  1  exception retire pulse to CSR file
wb_ecode  out  ECODE_W  retired exception code
wb_esubcode  out  ESUB_W  retired subcode
wb_pc  out  32  retired PC / ERA source
wb_vaddr  out  32  retired BADV source
ertn_flush  out  1  ERTN retire pulse
flush  out  1  pipeline flush (wb_ex | ertn_flush)
rf_we  out  1  GPR write enable
rf_waddr  out  REG_AW  GPR write address
rf_wdata  out  DATA_W  GPR write data
buf_count  out  log2(DEPTH)+1  occupied entries

Behaviour:
- Interface fixed: single clock clk; reset synchronous, active-high.
- Reset:
  - head, tail and count clear to 0.
  - All strobes (rf_we, csr_we, wb_ex, ertn_flush, flush) are 0.
  - Data outputs reflect the head slot and are don't-care while the buffer is empty.
- Buffer: circular FIFO, pointers wrap modulo DEPTH.
  - Enqueue: enq = ms_to_ws_valid & ws_allowin & ~flush.
  - Retire: fire = (count!=0) & ~commit_hold.
- ws_allowin = (count<DEPTH) | fire. Enqueue and retire may occur in the same cycle when full.
- Latency: an entry enqueued in cycle N is retireable in cycle N+1 at the earliest.
- Head classification, combinational:
  - int_take = has_int & ~head.ex.
  - exc = head.ex | int_take.
  - For int_take, wb_ecode=0 and wb_esubcode=0. Otherwise use the head codes.
  - ertn_eff = head.ertn & ~exc. Exception outranks ERTN.
- Outputs on fire:
  - wb_ex = exc.
  - ertn_flush = ertn_eff.
  - flush = wb_ex | ertn_flush.
  - csr_we = head.csr_we & ~exc.
  - rf_we = head.gr_we & ~exc.
  - rf_wdata = head.csr_re ? csr_rvalue : head.result.
  - Every strobe is 0 when fire=0.
- Flush:
  - The cycle after flush, count=0 and head=tail=0.
  - Any upstream valid presented during the flush cycle is dropped (ws_allowin stays as computed; enq is suppressed).
- commit_hold: the head is frozen and no strobe fires. Interrupt sampling re-evaluates each cycle.
- Reset mid-operation discards all entries; no strobe fires in the reset cycle.

Optional Feature:
WB_PERF_CNT_EN.
- Defined: adds output retired_cnt [63:0], reset to 0.
  - Increments by 1 on each fire with exc=0, ERTN included.
  - Wraps 0xFFFF_FFFF_FFFF_FFFF -> 0.
  - Adds output ex_cnt [31:0], counting wb_ex pulses.
- Undefined: both ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- DEPTH=2; push A(pc 0x1c000000, dest r4, result 0x5) and B(dest r5, result 0x7) back-to-back; hold=0 -> rf_we on cycles 2 and 3 with r4=0x5 then r5=0x7; buf_count never exceeds 1.
- Fill to full with hold=1 -> buf_count=2, ws_allowin=0; release hold with upstream valid -> ws_allowin=1 that cycle, count stays 2.
- Head ms_ex=1, ecode 0x08, gr_we=1, csr_we=1; second entry queued -> wb_ex=1, wb_ecode=0x08, flush=1, rf_we=0, csr_we=0; next cycle buf_count=0 and the upstream entry offered during flush is lost.
- has_int=1 while head is a plain add -> wb_ex=1, wb_ecode=0, rf_we=0, wb_pc=head pc.
- Head ERTN with ms_ex=0 -> ertn_flush=1, wb_ex=0; head ERTN with ms_ex=1 -> wb_ex=1, ertn_flush=0.
- CSR read csr_num=0x5, csr_rvalue=0xABCD, dest r6 -> rf_wdata=0xABCD; with WB_PERF_CNT_EN, retired_cnt increments by exactly the count of non-excepting retires.
